// File: rtl/ttt_turn_scheduler.sv
// ttt_turn_scheduler
// Sequences a single tic-tac-toe game over the 9-position board datapath.
// Turns strictly alternate between the player and the computer. Each move
// request from the side to move is validated against board occupancy and,
// when legal, turned into a one-hot write strobe to the position registers.
// A turn that sees no legal move for TIMEOUT_CYCLES cycles passes to the
// other side. MAX_ILLEGAL consecutive illegal requests in one turn forfeit
// the game. Win/draw scores saturate at 255 and persist across games.
//
// Ports
//   clock, reset         system clock, asynchronous active-high reset
//   start, first_pc      begin a new game (IDLE/DONE only); 1 = computer first
//   pl_req/pl_pos        player request (level) and position 0..8
//   pl_ack/pl_err        one-cycle consume pulse; err = request was illegal
//   pc_req/pc_pos        computer request and position
//   pc_ack/pc_err        computer consume pulse and illegal qualifier
//   board_occ            occupancy of positions 0..8 from the datapath
//   win, who, no_space   winner detector / no-space detector results
//   wr_en, wr_who        one-hot position write strobe and the writer (10 pc, 01 pl)
//   board_clr            one-cycle pulse clearing the position registers
//   turn                 01 player to move, 10 computer to move, 00 otherwise
//   game_over, result    DONE flag; 01 player won, 10 computer won, 11 draw
//   timeout_pulse        one-cycle pulse when a turn times out
//   pl_score, pc_score, draw_score   saturating game tallies

module ttt_turn_scheduler #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_ILLEGAL    = 3,
    parameter int TO_W           = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       first_pc,
    input  logic       pl_req,
    input  logic [3:0] pl_pos,
    output logic       pl_ack,
    output logic       pl_err,
    input  logic       pc_req,
    input  logic [3:0] pc_pos,
    output logic       pc_ack,
    output logic       pc_err,
    input  logic [8:0] board_occ,
    input  logic       win,
    input  logic [1:0] who,
    input  logic       no_space,
    output logic [8:0] wr_en,
    output logic [1:0] wr_who,
    output logic       board_clr,
    output logic [1:0] turn,
    output logic       game_over,
    output logic [1:0] result,
    output logic       timeout_pulse,
    output logic [7:0] pl_score,
    output logic [7:0] pc_score,
    output logic [7:0] draw_score
);

    localparam int IL_W = $clog2(MAX_ILLEGAL + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_TURN_PL,
        S_TURN_PC,
        S_COMMIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          r_state;
    logic            r_firstPc;
    logic [1:0]      r_mover;
    logic [TO_W-1:0] r_toCnt;
    logic [IL_W-1:0] r_illCnt;
    logic            r_plWait;
    logic            r_pcWait;
    logic            r_plAck;
    logic            r_plErr;
    logic            r_pcAck;
    logic            r_pcErr;
    logic [8:0]      r_wrEn;
    logic [1:0]      r_wrWho;
    logic            r_boardClr;
    logic [1:0]      r_turn;
    logic            r_gameOver;
    logic [1:0]      r_result;
    logic            r_timeoutPulse;
    logic [7:0]      r_plScore;
    logic [7:0]      r_pcScore;
    logic [7:0]      r_drawScore;

    logic [8:0] w_plOnehot;
    logic [8:0] w_pcOnehot;
    logic       w_plLegal;
    logic       w_pcLegal;
    logic       w_isPl;
    logic       w_actReq;
    logic       w_actLegal;
    logic [8:0] w_actOnehot;
    logic [1:0] w_side;
    logic [1:0] w_other;
    logic       w_toExpire;
    logic       w_illLast;

    // Positions 9..15 shift the single bit out of the 9-bit vector, so the
    // one-hot is zero for them and the range test alone rejects them.
    assign w_plOnehot = 9'd1 << pl_pos;
    assign w_pcOnehot = 9'd1 << pc_pos;
    assign w_plLegal  = (pl_pos <= 4'd8) && ((board_occ & w_plOnehot) == 9'd0);
    assign w_pcLegal  = (pc_pos <= 4'd8) && ((board_occ & w_pcOnehot) == 9'd0);

    // Only the side that holds the turn is looked at. A side that was just
    // rejected stays blind until it drops its request for a cycle.
    assign w_isPl      = (r_state == S_TURN_PL);
    assign w_actReq    = w_isPl ? (pl_req && !r_plWait) : (pc_req && !r_pcWait);
    assign w_actLegal  = w_isPl ? w_plLegal : w_pcLegal;
    assign w_actOnehot = w_isPl ? w_plOnehot : w_pcOnehot;
    assign w_side      = w_isPl ? 2'b01 : 2'b10;
    assign w_other     = w_isPl ? 2'b10 : 2'b01;
    assign w_toExpire  = (r_toCnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_illLast   = (r_illCnt == IL_W'(MAX_ILLEGAL - 1));

    // Game sequencer. All outputs are registered here; pulses default low
    // every cycle and are raised only in the cycle they belong to. A legal
    // move raises ack and wr_en together, COMMIT drops the strobe so the
    // position register and detectors settle, and CHECK decides the outcome.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_firstPc      <= 1'b0;
            r_mover        <= 2'b00;
            r_toCnt        <= '0;
            r_illCnt       <= '0;
            r_plWait       <= 1'b0;
            r_pcWait       <= 1'b0;
            r_plAck        <= 1'b0;
            r_plErr        <= 1'b0;
            r_pcAck        <= 1'b0;
            r_pcErr        <= 1'b0;
            r_wrEn         <= 9'd0;
            r_wrWho        <= 2'b00;
            r_boardClr     <= 1'b0;
            r_turn         <= 2'b00;
            r_gameOver     <= 1'b0;
            r_result       <= 2'b00;
            r_timeoutPulse <= 1'b0;
            r_plScore      <= 8'd0;
            r_pcScore      <= 8'd0;
            r_drawScore    <= 8'd0;
        end else begin
            r_plAck        <= 1'b0;
            r_plErr        <= 1'b0;
            r_pcAck        <= 1'b0;
            r_pcErr        <= 1'b0;
            r_boardClr     <= 1'b0;
            r_timeoutPulse <= 1'b0;
            if (!pl_req) r_plWait <= 1'b0;
            if (!pc_req) r_pcWait <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_firstPc  <= first_pc;
                        r_result   <= 2'b00;
                        r_gameOver <= 1'b0;
                        r_boardClr <= 1'b1;
                        r_state    <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    r_toCnt  <= '0;
                    r_illCnt <= '0;
                    if (r_firstPc) begin
                        r_turn  <= 2'b10;
                        r_state <= S_TURN_PC;
                    end else begin
                        r_turn  <= 2'b01;
                        r_state <= S_TURN_PL;
                    end
                end

                S_TURN_PL, S_TURN_PC: begin
                    // A legal request beats a timeout landing in the same cycle.
                    if (w_actReq && w_actLegal) begin
                        if (w_isPl) r_plAck <= 1'b1;
                        else        r_pcAck <= 1'b1;
                        r_wrEn   <= w_actOnehot;
                        r_wrWho  <= w_side;
                        r_mover  <= w_side;
                        r_turn   <= 2'b00;
                        r_toCnt  <= '0;
                        r_illCnt <= '0;
                        r_state  <= S_COMMIT;
                    end else if (w_actReq && w_illLast) begin
                        // Final illegal request forfeits the game to the other side.
                        if (w_isPl) begin
                            r_plAck  <= 1'b1;
                            r_plErr  <= 1'b1;
                            r_plWait <= 1'b1;
                            if (r_pcScore != 8'hFF) r_pcScore <= r_pcScore + 8'd1;
                        end else begin
                            r_pcAck  <= 1'b1;
                            r_pcErr  <= 1'b1;
                            r_pcWait <= 1'b1;
                            if (r_plScore != 8'hFF) r_plScore <= r_plScore + 8'd1;
                        end
                        r_result   <= w_other;
                        r_gameOver <= 1'b1;
                        r_turn     <= 2'b00;
                        r_toCnt    <= '0;
                        r_illCnt   <= '0;
                        r_state    <= S_DONE;
                    end else begin
                        if (w_actReq) begin
                            if (w_isPl) begin
                                r_plAck  <= 1'b1;
                                r_plErr  <= 1'b1;
                                r_plWait <= 1'b1;
                            end else begin
                                r_pcAck  <= 1'b1;
                                r_pcErr  <= 1'b1;
                                r_pcWait <= 1'b1;
                            end
                            r_illCnt <= r_illCnt + IL_W'(1);
                        end
                        // The turn-pass clear of the illegal count overrides the
                        // increment above when both happen in one cycle.
                        if (w_toExpire) begin
                            r_timeoutPulse <= 1'b1;
                            r_turn         <= w_other;
                            r_toCnt        <= '0;
                            r_illCnt       <= '0;
                            r_state        <= w_isPl ? S_TURN_PC : S_TURN_PL;
                        end else begin
                            r_toCnt <= r_toCnt + TO_W'(1);
                        end
                    end
                end

                S_COMMIT: begin
                    r_wrEn  <= 9'd0;
                    r_wrWho <= 2'b00;
                    r_state <= S_CHECK;
                end

                S_CHECK: begin
                    if (win) begin
                        r_result   <= who;
                        r_gameOver <= 1'b1;
                        if (who == 2'b01 && r_plScore != 8'hFF) r_plScore <= r_plScore + 8'd1;
                        if (who == 2'b10 && r_pcScore != 8'hFF) r_pcScore <= r_pcScore + 8'd1;
                        r_state    <= S_DONE;
                    end else if (no_space) begin
                        r_result   <= 2'b11;
                        r_gameOver <= 1'b1;
                        if (r_drawScore != 8'hFF) r_drawScore <= r_drawScore + 8'd1;
                        r_state    <= S_DONE;
                    end else begin
                        r_toCnt  <= '0;
                        r_illCnt <= '0;
                        if (r_mover == 2'b01) begin
                            r_turn  <= 2'b10;
                            r_state <= S_TURN_PC;
                        end else begin
                            r_turn  <= 2'b01;
                            r_state <= S_TURN_PL;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pl_ack        = r_plAck;
    assign pl_err        = r_plErr;
    assign pc_ack        = r_pcAck;
    assign pc_err        = r_pcErr;
    assign wr_en         = r_wrEn;
    assign wr_who        = r_wrWho;
    assign board_clr     = r_boardClr;
    assign turn          = r_turn;
    assign game_over     = r_gameOver;
    assign result        = r_result;
    assign timeout_pulse = r_timeoutPulse;
    assign pl_score      = r_plScore;
    assign pc_score      = r_pcScore;
    assign draw_score    = r_drawScore;

endmodule

// File: tb/tb_ttt_turn_scheduler.sv
// tb_ttt_turn_scheduler
// Directed bench for ttt_turn_scheduler. A small board model stands in for
// the position registers (cleared by board_clr, filled by wr_en) and feeds
// board_occ back; win/who/no_space are driven directly as detector stubs.
// A table of per-cycle vectors covers a full won game and an illegal-move
// forfeit; hand-written sequences cover timeout, draw and win priority,
// inactive-side requests, ignored start, reset mid-game and score saturation.

module tb_ttt_turn_scheduler;

    logic       clock;
    logic       reset;
    logic       start;
    logic       first_pc;
    logic       pl_req;
    logic [3:0] pl_pos;
    logic       pl_ack;
    logic       pl_err;
    logic       pc_req;
    logic [3:0] pc_pos;
    logic       pc_ack;
    logic       pc_err;
    logic [8:0] board_occ;
    logic       win;
    logic [1:0] who;
    logic       no_space;
    logic [8:0] wr_en;
    logic [1:0] wr_who;
    logic       board_clr;
    logic [1:0] turn;
    logic       game_over;
    logic [1:0] result;
    logic       timeout_pulse;
    logic [7:0] pl_score;
    logic [7:0] pc_score;
    logic [7:0] draw_score;

    logic [8:0] boardModel;

    int nChecks = 0;
    int nPass   = 0;

    typedef struct {
        logic       start;
        logic       firstPc;
        logic       plReq;
        logic [3:0] plPos;
        logic       pcReq;
        logic [3:0] pcPos;
        logic       win;
        logic [1:0] who;
        logic       noSpace;
        logic [21:0] expOut;
    } vec_t;

    vec_t vecs[$];

    ttt_turn_scheduler #(
        .TIMEOUT_CYCLES(8),
        .MAX_ILLEGAL(3),
        .TO_W(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .first_pc(first_pc),
        .pl_req(pl_req),
        .pl_pos(pl_pos),
        .pl_ack(pl_ack),
        .pl_err(pl_err),
        .pc_req(pc_req),
        .pc_pos(pc_pos),
        .pc_ack(pc_ack),
        .pc_err(pc_err),
        .board_occ(board_occ),
        .win(win),
        .who(who),
        .no_space(no_space),
        .wr_en(wr_en),
        .wr_who(wr_who),
        .board_clr(board_clr),
        .turn(turn),
        .game_over(game_over),
        .result(result),
        .timeout_pulse(timeout_pulse),
        .pl_score(pl_score),
        .pc_score(pc_score),
        .draw_score(draw_score)
    );

    // 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in for the nine position registers.
    always @(posedge clock or posedge reset) begin
        if (reset)          boardModel <= 9'd0;
        else if (board_clr) boardModel <= 9'd0;
        else                boardModel <= boardModel | wr_en;
    end
    assign board_occ = boardModel;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [21:0] packOut();
        return {pl_ack, pc_ack, pl_err, pc_err, wr_en, wr_who, turn,
                game_over, result, board_clr, timeout_pulse};
    endfunction

    // ack/err are {player, computer}.
    function automatic void addVec(int s, int fpc, int plq, int plp, int pcq, int pcp,
                                   int w, int wh, int ns, int ack, int err, int wr,
                                   int wwho, int trn, int over, int res, int clr, int to);
        vec_t v;
        v.start   = 1'(s);
        v.firstPc = 1'(fpc);
        v.plReq   = 1'(plq);
        v.plPos   = 4'(plp);
        v.pcReq   = 1'(pcq);
        v.pcPos   = 4'(pcp);
        v.win     = 1'(w);
        v.who     = 2'(wh);
        v.noSpace = 1'(ns);
        v.expOut  = {2'(ack), 2'(err), 9'(wr), 2'(wwho), 2'(trn), 1'(over),
                     2'(res), 1'(clr), 1'(to)};
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input vec_t v);
        start    = v.start;
        first_pc = v.firstPc;
        pl_req   = v.plReq;
        pl_pos   = v.plPos;
        pc_req   = v.pcReq;
        pc_pos   = v.pcPos;
        win      = v.win;
        who      = v.who;
        no_space = v.noSpace;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One player win from IDLE/DONE: start, move to 0, win reported at CHECK.
    task automatic playerWinGame();
        start = 1'b1; first_pc = 1'b0; tick();
        start = 1'b0; tick();
        pl_req = 1'b1; pl_pos = 4'd0; tick();
        pl_req = 1'b0; tick();
        win = 1'b1; who = 2'b01; tick();
        win = 1'b0; who = 2'b00;
    endtask

    int pulseAt;
    logic sawWrite;
    logic sawAck;

    initial begin
        reset = 1'b1; start = 1'b0; first_pc = 1'b0;
        pl_req = 1'b0; pl_pos = 4'd0; pc_req = 1'b0; pc_pos = 4'd0;
        win = 1'b0; who = 2'b00; no_space = 1'b0;

        // Game 1: player 0,1,2 / computer 4,8, player wins after 5th commit.
        addVec(1,0, 0,0, 0,0, 0,0,0, 'b00,'b00,'h000,'b00,'b00,0,'b00,1,0);
        addVec(0,0, 0,0, 0,0, 0,0,0, 'b00,'b00,'h000,'b00,'b01,0,'b00,0,0);
        addVec(0,0, 1,0, 0,0, 0,0,0, 'b10,'b00,'h001,'b01,'b00,0,'b00,0,0);
        addVec(0,0, 0,0, 0,0, 0,0,0, 'b00,'b00,'h000,'b00,'b00,0,'b00,0,0);
        addVec(0,0, 0,0, 0,0, 0,0,0, 'b00,'b00,'h000,'b00,'b10,0,'b00,0,0);
        addVec(0,0, 0,0, 1,4, 0,0,0, 'b01,'b00,'h010,'b10,'b00,0,'b00,0,0);
        addVec(0,0, 0,0, 0,0, 0,0,0, 'b00,'b00,'h000,'b00,'b00,0,'b00,0,0);
        addVec(0,0, 0,0, 0,0, 0,0,0, 'b00,'b00,'h000,'b00,'b01,0,'b00,0,0);
        addVec(0,0, 1,1, 0,0, 0,0,0, 'b10,'b00,'h002,'b01,'b00,0,'b00,0,0);
        addVec(0,0, 0,0, 0,0, 0,0,0, 'b00,'b00,'h000,'b00,'b00,0,'b00,0,0);
        addVec(0,0, 0,0, 0,0, 0,0,0, 'b00,'b00,'h000,'b00,'b10,0,'b00,0,0);
        addVec(0,0, 0,0, 1,8, 0,0,0, 'b01,'b00,'h100,'b10,'b00,0,'b00,0,0);
        addVec(0,0, 0,0, 0,0, 0,0,0, 'b00,'b00,'h000,'b00,'b00,0,'b00,0,0);
        addVec(0,0, 0,0, 0,0, 0,0,0, 'b00,'b00,'h000,'b00,'b01,0,'b00,0,0);
        addVec(0,0, 1,2, 0,0, 0,0,0, 'b10,'b00,'h004,'b01,'b00,0,'b00,0,0);
        addVec(0,0, 0,0, 0,0, 0,0,0, 'b00,'b00,'h000,'b00,'b00,0,'b00,0,0);
        addVec(0,0, 0,0, 0,0, 1,1,0, 'b00,'b00,'h000,'b00,'b00,1,'b01,0,0);
        // Game 2: player 0, computer 4, then three illegal player requests.
        addVec(1,0, 0,0, 0,0, 0,0,0, 'b00,'b00,'h000,'b00,'b00,0,'b00,1,0);
        addVec(0,0, 0,0, 0,0, 0,0,0, 'b00,'b00,'h000,'b00,'b01,0,'b00,0,0);
        addVec(0,0, 1,0, 0,0, 0,0,0, 'b10,'b00,'h001,'b01,'b00,0,'b00,0,0);
        addVec(0,0, 0,0, 0,0, 0,0,0, 'b00,'b00,'h000,'b00,'b00,0,'b00,0,0);
        addVec(0,0, 0,0, 0,0, 0,0,0, 'b00,'b00,'h000,'b00,'b10,0,'b00,0,0);
        addVec(0,0, 0,0, 1,4, 0,0,0, 'b01,'b00,'h010,'b10,'b00,0,'b00,0,0);
        addVec(0,0, 0,0, 0,0, 0,0,0, 'b00,'b00,'h000,'b00,'b00,0,'b00,0,0);
        addVec(0,0, 0,0, 0,0, 0,0,0, 'b00,'b00,'h000,'b00,'b01,0,'b00,0,0);
        addVec(0,0, 1,4, 0,0, 0,0,0, 'b10,'b10,'h000,'b00,'b01,0,'b00,0,0);
        addVec(0,0, 1,4, 0,0, 0,0,0, 'b00,'b00,'h000,'b00,'b01,0,'b00,0,0);
        addVec(0,0, 0,0, 0,0, 0,0,0, 'b00,'b00,'h000,'b00,'b01,0,'b00,0,0);
        addVec(0,0, 1,10,0,0, 0,0,0, 'b10,'b10,'h000,'b00,'b01,0,'b00,0,0);
        addVec(0,0, 0,0, 0,0, 0,0,0, 'b00,'b00,'h000,'b00,'b01,0,'b00,0,0);
        addVec(0,0, 1,10,0,0, 0,0,0, 'b10,'b10,'h000,'b00,'b00,1,'b10,0,0);
        addVec(0,0, 0,0, 0,0, 0,0,0, 'b00,'b00,'h000,'b00,'b00,1,'b10,0,0);
        addVec(0,0, 1,5, 0,0, 0,0,0, 'b00,'b00,'h000,'b00,'b00,1,'b10,0,0);
        addVec(0,0, 0,0, 0,0, 0,0,0, 'b00,'b00,'h000,'b00,'b00,1,'b10,0,0);

        // Reset state.
        tick(); tick();
        checkOutput("reset_outputs", 32'(packOut()), 32'd0);
        checkOutput("reset_scores", {8'd0, pl_score, pc_score, draw_score}, 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), 32'(packOut()), 32'(vecs[i].expOut));
        end
        checkOutput("scores_after_table", {8'd0, pl_score, pc_score, draw_score}, 32'h00010100);

        // Timeout: player idles, pulse lands 8 edges after the turn starts.
        start = 1'b1; first_pc = 1'b0; tick();
        start = 1'b0; tick();
        checkOutput("to_turn_start", 32'(turn), 32'h1);
        pulseAt = 0; sawWrite = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (wr_en != 9'd0) sawWrite = 1'b1;
            if (timeout_pulse) begin
                pulseAt = k;
                break;
            end
        end
        checkOutput("to_latency", 32'(pulseAt), 32'd8);
        checkOutput("to_turn_passed", 32'(turn), 32'h2);
        checkOutput("to_no_write", 32'(sawWrite), 32'd0);
        tick();
        checkOutput("to_pulse_width", 32'(timeout_pulse), 32'd0);

        // Draw: computer moves, detectors report a full board without a win.
        pc_req = 1'b1; pc_pos = 4'd0; tick();
        checkOutput("draw_pc_move", {pc_ack, pc_err, wr_en, wr_who}, {2'b10, 9'h001, 2'b10});
        pc_req = 1'b0; tick();
        no_space = 1'b1; tick();
        no_space = 1'b0;
        checkOutput("draw_result", {game_over, result}, 3'b111);
        checkOutput("draw_score", 32'(draw_score), 32'd1);

        // Win beats draw; computer moves first this game.
        start = 1'b1; first_pc = 1'b1; tick();
        start = 1'b0; tick();
        checkOutput("pc_first_turn", 32'(turn), 32'h2);
        pc_req = 1'b1; pc_pos = 4'd5; tick();
        pc_req = 1'b0; tick();
        win = 1'b1; who = 2'b10; no_space = 1'b1; tick();
        win = 1'b0; who = 2'b00; no_space = 1'b0;
        checkOutput("win_priority", {game_over, result}, 3'b110);
        checkOutput("win_priority_scores", {pc_score, draw_score}, {8'd2, 8'd1});

        // Inactive side and mid-game start are ignored.
        start = 1'b1; first_pc = 1'b0; tick();
        start = 1'b0; tick();
        pc_req = 1'b1; pc_pos = 4'd3;
        sawAck = 1'b0; sawWrite = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (pc_ack) sawAck = 1'b1;
            if (wr_en != 9'd0) sawWrite = 1'b1;
        end
        checkOutput("inactive_no_ack_write", {sawAck, sawWrite, turn}, 4'b0001);
        start = 1'b1; tick();
        start = 1'b0; pc_req = 1'b0;
        checkOutput("midgame_start_ignored", {board_clr, turn}, 3'b001);
        pl_req = 1'b1; pl_pos = 4'd3; tick();
        checkOutput("pl_move_3", {pl_ack, pl_err, wr_en, wr_who}, {2'b10, 9'h008, 2'b01});

        // Reset during COMMIT clears everything at once.
        reset = 1'b1; #1;
        pl_req = 1'b0;
        checkOutput("reset_commit_outputs", 32'(packOut()), 32'd0);
        checkOutput("reset_commit_scores", {8'd0, pl_score, pc_score, draw_score}, 32'd0);
        tick();
        reset = 1'b0;
        start = 1'b1; first_pc = 1'b0; tick();
        start = 1'b0;
        checkOutput("restart_clr_on", 32'(board_clr), 32'd1);
        tick();
        checkOutput("restart_clr_off", {board_clr, turn}, 3'b001);

        // Finish this game as a player win, then 254 more to reach 255.
        pl_req = 1'b1; pl_pos = 4'd0; tick();
        pl_req = 1'b0; tick();
        win = 1'b1; who = 2'b01; tick();
        win = 1'b0; who = 2'b00;
        checkOutput("first_win_after_reset", 32'(pl_score), 32'd1);
        for (int g = 0; g < 254; g++) playerWinGame();
        checkOutput("score_reach_255", 32'(pl_score), 32'd255);
        playerWinGame();
        playerWinGame();
        checkOutput("score_saturated", {pl_score, pc_score, draw_score}, {8'd255, 8'd0, 8'd0});

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/ttt_turn_scheduler.md
Name: ttt_turn_scheduler

Overview:
Sequences one tic-tac-toe game on the 9-position board datapath: position registers, winner detector and no-space detector.
- Arbitrates move requests from two requesters (player, computer) by strict alternating turns, validates each move and issues one-hot write strobes to the position registers.
- Enforces a per-turn timeout and a consecutive-illegal-move limit, then declares the result.
- Keeps saturating win/draw scores across games.

Parameters:
TIMEOUT_CYCLES, 1000, cycles a side may hold the turn without a legal move before the turn passes (>=2)
MAX_ILLEGAL, 3, consecutive illegal requests in one turn that forfeit the game (>=1)
TO_W, 10, width of timeout counter (must hold TIMEOUT_CYCLES-1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin new game; honoured only in IDLE or DONE
first_pc  in  1  sampled with start: 1 = computer moves first
pl_req  in  1  player move request, level, held until ack
pl_pos  in  4  player position 0..8
pl_ack  out  1  one-cycle pulse, request consumed
pl_err  out  1  qualifies pl_ack: 1 = rejected as illegal
pc_req  in  1  computer move request
pc_pos  in  4  computer position 0..8
pc_ack  out  1  one-cycle pulse
pc_err  out  1  qualifies pc_ack
board_occ  in  9  occupancy of positions 0..8, bit = |posN
win  in  1  winner detector output
who  in  2  01 player, 10 computer
no_space  in  1  board full
wr_en  out  9  one-hot write strobe to position registers
wr_who  out  2  10 computer, 01 player; valid with wr_en
board_clr  out  1  one-cycle pulse clearing position registers
turn  out  2  01 player turn, 10 computer turn, 00 otherwise
game_over  out  1  high in DONE
result  out  2  01 player won, 10 computer won, 11 draw, 00 none
timeout_pulse  out  1  one-cycle pulse on turn timeout
pl_score  out  8  player wins, saturating at 255
pc_score  out  8  computer wins, saturating
draw_score  out  8  draws, saturating

Behaviour:
- Reset: state IDLE, all outputs 0, all counters 0, scores 0. Reset mid-game aborts the game and clears scores.
- States: IDLE, CLEAR, TURN_PL, TURN_PC, COMMIT, CHECK, DONE.
- IDLE/DONE + start=1 -> CLEAR.
  - Register first_pc; result<=00; game_over<=0.
  - start in any other state is ignored.
- CLEAR: board_clr=1 for exactly one cycle -> TURN_PC if first_pc, else TURN_PL. Timeout and illegal counters are cleared.
- TURN_x: turn shows the side to move. Only the active side's request is examined; the inactive side gets no ack, whatever its req.
  - Request legal (pos<=8 and board_occ[pos]==0): ack=1, err=0, and in the same cycle wr_en[pos]=1 with wr_who set -> COMMIT.
  - Request illegal (pos>=9 or occupied): ack=1, err=1, no write, illegal count +1. The requester must drop req for at least one cycle before a new request is examined.
  - Illegal count reaching MAX_ILLEGAL -> DONE; result = the other side; that side's score +1.
  - No legal request: timeout counter +1. At TIMEOUT_CYCLES-1: timeout_pulse=1 and the turn passes to the other side, with both counters cleared.
  - A timeout and a legal request in the same cycle: the request wins, no timeout.
- COMMIT: one wait cycle so the position register and detectors settle. wr_en=0 -> CHECK.
- CHECK: sample win/who/no_space.
  - win=1 -> DONE; result=who; matching score +1.
  - Else no_space=1 -> DONE; result=11; draw_score +1.
  - Else -> the other side's TURN with counters cleared.
  - Win has priority over draw.
- Latency: an accepted request shows wr_en in its ack cycle. Result is visible 2 cycles after the ack edge.
- DONE: game_over=1; result is held until the next start. Requests are ignored.
- Scores saturate at 255 and never wrap.
- wr_en is always zero or one-hot. Datapath board contents are never written outside a legal ack cycle.

Test Plan:
1. Reset, start with first_pc=0; player moves 0, 1, 2; computer moves 4, 8; stub win=1, who=01 after the 5th commit -> result=01, game_over=1, pl_score=1, wr_en sequence 001h, 010h, 002h, 100h, 004h.
2. Player requests pos 4 when board_occ[4]=1 -> pl_ack=1, pl_err=1, wr_en=0, still TURN_PL. Then request pos 10 twice more (MAX_ILLEGAL=3) -> DONE, result=10, pc_score=1.
3. TIMEOUT_CYCLES=8, player idle in TURN_PL -> timeout_pulse exactly 8 cycles after turn start, turn=10, no write.
4. Full board with no_space=1, win=0 at CHECK -> result=11, draw_score=1. Same again but with win=1, who=10 -> result=10, win takes priority.
5. Computer asserts pc_req with pos 3 during TURN_PL -> no pc_ack, no write. start asserted mid-game -> ignored, no board_clr.
6. Assert reset during COMMIT -> all outputs 0 immediately, scores 0. Next start produces one board_clr pulse. Force pl_score=255 via repeated wins -> it stays 255.
